ir: RTL and testbench

IR -- requirements
Module: ir

---
 rtl/ir.sv | 82 ++++++++
 tb/tb_ir.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ir.sv
// Instruction register: captures an opcode byte and up to three operand bytes from a fetched word.
// Optional build macro IR_OPERAND_MASK_EN zeroes operand bytes beyond the sampled operand length.
module ir #(
   parameter logic [7:0] RESET_INSN = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] raw,
   input  logic [1:0]  len,
   input  logic        we,
   output logic [7:0]  insn,
   output logic [7:0]  d1,
   output logic [7:0]  d2,
   output logic [7:0]  d3
);

   // Returns the operand byte, or zero when its index lies beyond the operand count.
   function automatic logic [7:0] operand_byte(input logic [7:0] value,
                                               input logic [1:0] index,
                                               input logic [1:0] count);
      logic [7:0] result;
      if (index > count) begin
         result = 8'h00;
      end else begin
         result = value;
      end
      return result;
   endfunction

   logic [7:0] insn_r;
   logic [7:0] d1_r;
   logic [7:0] d2_r;
   logic [7:0] d3_r;
   logic [7:0] d1_next_s;
   logic [7:0] d2_next_s;
   logic [7:0] d3_next_s;

`ifdef IR_OPERAND_MASK_EN
   // Operand bytes past len are forced to zero before capture.
   always_comb begin
      d1_next_s = operand_byte(raw[15:8],  2'd1, len);
      d2_next_s = operand_byte(raw[23:16], 2'd2, len);
      d3_next_s = operand_byte(raw[31:24], 2'd3, len);
   end
`else
   logic unused_len_s;
   assign unused_len_s = ^len;

   // Without masking every operand byte is captured as fetched.
   always_comb begin
      d1_next_s = operand_byte(raw[15:8],  2'd1, 2'd3);
      d2_next_s = operand_byte(raw[23:16], 2'd2, 2'd3);
      d3_next_s = operand_byte(raw[31:24], 2'd3, 2'd3);
   end
`endif

   // Capture register: reset dominates, otherwise load on we and hold when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         insn_r <= RESET_INSN;
         d1_r   <= 8'h00;
         d2_r   <= 8'h00;
         d3_r   <= 8'h00;
      end else if (we) begin
         insn_r <= raw[7:0];
         d1_r   <= d1_next_s;
         d2_r   <= d2_next_s;
         d3_r   <= d3_next_s;
      end else begin
         insn_r <= insn_r;
         d1_r   <= d1_r;
         d2_r   <= d2_r;
         d3_r   <= d3_r;
      end
   end

   assign insn = insn_r;
   assign d1   = d1_r;
   assign d2   = d2_r;
   assign d3   = d3_r;

endmodule

// File: tb/tb_ir.sv
// Randomized self-checking bench for ir against a byte-level reference model.
module tb_ir;

`ifdef IR_OPERAND_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] raw;
   logic [1:0]  len;
   logic        we;
   logic [7:0]  insn, d1, d2, d3;
   logic [31:0] obs;
   logic [31:0] exp_s;
   int          nvec = 0;
   int          nerr = 0;

   ir #(.RESET_INSN(8'h00)) dut (
      .clk(clk), .rst(rst), .raw(raw), .len(len), .we(we),
      .insn(insn), .d1(d1), .d2(d2), .d3(d3)
   );

   always #5 clk = ~clk;
   assign obs = {insn, d1, d2, d3};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Expected {insn,d1,d2,d3} after loading word w with operand count n.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] n);
      logic [7:0] b [4];
      for (int i = 0; i < 4; i++) begin
         b[i] = w[8*i +: 8];
         if (MASK && i > int'(n)) b[i] = 8'h00;
      end
      return {b[0], b[1], b[2], b[3]};
   endfunction

   task automatic tick();
      if (rst === 1'b1 && we === 1'b1) exp_s = ref_load(raw, len);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; raw = 32'h0; len = 2'd0; exp_s = 32'h0;
      #2;
      chk("reset_state", obs, 32'h0000_0000);
      tick();
      #2 rst = 1'b1;
      tick();
      chk("idle_after_reset", obs, 32'h0000_0000);

      raw = 32'h5E606202; len = 2'd2; we = 1'b1;
      tick();
      chk("load_len2", obs, MASK ? 32'h0262_6000 : 32'h0262_605E);
      we = 1'b0; len = 2'd1;
      tick();
      chk("hold_len_change", obs, MASK ? 32'h0262_6000 : 32'h0262_605E);

      raw = 32'hDFE342FE;
      tick();
      chk("hold_raw_change", obs, MASK ? 32'h0262_6000 : 32'h0262_605E);
      we = 1'b1;
      tick();
      chk("load_len1", obs, MASK ? 32'hFE42_0000 : 32'hFE42_E3DF);

      len = 2'd0;
      tick();
      chk("load_len0", obs, MASK ? 32'hFE00_0000 : 32'hFE42_E3DF);
      len = 2'd3;
      tick();
      chk("load_len3", obs, 32'hFE42_E3DF);

      #3 rst = 1'b0;
      #1;
      chk("async_reset", obs, 32'h0000_0000);
      exp_s = 32'h0;

      raw = 32'h3249FD2A; len = 2'd3; we = 1'b1;
      tick();
      chk("reset_over_we", obs, 32'h0000_0000);
      #2 rst = 1'b1;
      tick();
      chk("load_after_release", obs, 32'h2AFD_4932);

      raw = 32'h5E606202; len = 2'd0;
      tick();
      chk("len0_macro", obs, MASK ? 32'h0200_0000 : 32'h0262_605E);
      we = 1'b0;
      tick();

      for (int i = 0; i < 400; i++) begin
         raw = $urandom;
         len = 2'($urandom_range(0, 3));
         we  = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 15) != 0);
         if (!rst) begin
            #1;
            exp_s = 32'h0;
            chk("rand_async_reset", obs, 32'h0000_0000);
         end
         tick();
         chk("rand", obs, exp_s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
